// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned WORD_W    = 32;
   // Bytes per word; the header is one word as well.
   localparam int unsigned HDR_BYTES = 4;
   localparam int unsigned BCNT_W    = $clog2(HDR_BYTES);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StHdr,
      StData,
      StDone,
      StErr
   } boot_state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// MSB-first byte-to-word assembler shared by the header and the data words.
// word_done_o pulses combinationally on the byte that completes a word, with
// the full word presented on word_o in the same cycle.
module boot_word_assembler
   import boot_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              byte_en_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic              word_done_o,
   output logic [WORD_W-1:0] word_o
);

   // Only the three most recent bytes need storing; the fourth arrives live.
   logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
   logic [BCNT_W-1:0]        cnt_q, cnt_d;

   // Shift in accepted bytes and flag the last byte of each word.
   always_comb begin
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      word_done_o = 1'b0;
      word_o      = {shift_q, byte_i};
      if (clr_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (byte_en_i) begin
         shift_d     = {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
         cnt_d       = cnt_q + 1'b1;
         word_done_o = (cnt_q == BCNT_W'(HDR_BYTES - 1));
      end
   end

   // Assembler state; reset discards any partial word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: receives a word-count header and N words
// (all MSB first) from a byte stream, writes them to imem word addresses
// 0..N-1, then raises start_o. Optional feature macro BOOT_CLEAR_EN adds a
// CLEAR pass that zeroes the whole memory before the header is accepted.
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              start_o,
   output logic              busy_o,
   output logic              err_o
);

   // One extra bit so a count of exactly DEPTH is representable.
   localparam int unsigned IDX_W = ADDR_W + 1;

   boot_state_t       state_q, state_d;
   logic [IDX_W-1:0]  word_idx_q, word_idx_d;
   logic [IDX_W-1:0]  n_q, n_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              start_q, start_d;
`ifdef BOOT_CLEAR_EN
   logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
`endif

   logic              byte_ready;
   logic              byte_en;
   logic              word_done;
   logic [WORD_W-1:0] word;

   assign byte_ready = (state_q == StHdr) || (state_q == StData);
   assign byte_en    = byte_valid_i & byte_ready;

   boot_word_assembler u_asm (
      .clk_i       (clk_i),
      .rst_ni      (rst_i),
      .clr_i       (state_q == StIdle),
      .byte_en_i   (byte_en),
      .byte_i      (byte_data_i),
      .word_done_o (word_done),
      .word_o      (word)
   );

   // Next-state and registered-output computation for the load sequence.
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      n_d        = n_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      // start follows DONE by one edge so the final write lands first.
      start_d    = (state_q == StDone);
`ifdef BOOT_CLEAR_EN
      clr_idx_d  = clr_idx_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (load_i) begin
`ifdef BOOT_CLEAR_EN
               // First clear write is issued here so CLEAR spans exactly DEPTH cycles.
               state_d   = StClear;
               we_d      = 1'b1;
               addr_d    = '0;
               wdata_d   = '0;
               clr_idx_d = IDX_W'(1);
`else
               state_d = StHdr;
`endif
            end
         end
`ifdef BOOT_CLEAR_EN
         StClear: begin
            if (clr_idx_q == IDX_W'(DEPTH)) begin
               state_d = StHdr;
            end else begin
               we_d      = 1'b1;
               addr_d    = clr_idx_q[ADDR_W-1:0];
               wdata_d   = '0;
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
`endif
         StHdr: begin
            if (word_done) begin
               if (word == '0) begin
                  state_d = StDone;
               end else if (word > 32'(DEPTH)) begin
                  state_d = StErr;
               end else begin
                  state_d    = StData;
                  n_d        = word[IDX_W-1:0];
                  word_idx_d = '0;
               end
            end
         end
         StData: begin
            if (word_done) begin
               we_d       = 1'b1;
               addr_d     = word_idx_q[ADDR_W-1:0];
               wdata_d    = word;
               word_idx_d = word_idx_q + 1'b1;
               if (word_idx_d == n_q) begin
                  state_d = StDone;
               end
            end
         end
         default: ; // DONE and ERR are terminal until reset
      endcase
   end

   // All loader state and registered outputs; async reset returns to IDLE.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         word_idx_q <= '0;
         n_q        <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         start_q    <= 1'b0;
`ifdef BOOT_CLEAR_EN
         clr_idx_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         n_q        <= n_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         start_q    <= start_d;
`ifdef BOOT_CLEAR_EN
         clr_idx_q  <= clr_idx_d;
`endif
      end
   end

   assign byte_ready_o = byte_ready;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign start_o      = start_q;
   assign busy_o       = (state_q == StClear) || (state_q == StHdr) || (state_q == StData);
   assign err_o        = (state_q == StErr);

endmodule
